// File: rtl/instruction_decoder.sv
// rtl/instruction_decoder.sv - decode stage: instruction decode, zero flag, pipeline copies, debug counters
module instruction_decoder #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             sync_reset,
   input  logic [7:0]       pm_data,
   input  logic [7:0]       pc,
   input  logic             alu_zero,
   output logic             jmp,
   output logic             jmp_nz,
   output logic [3:0]       jmp_addr,
   output logic             dont_jmp,
   output logic             NOPC8,
   output logic             NOPCF,
   output logic             NOPD8,
   output logic             NOPDF,
   output logic [7:0]       reg_en,
   output logic [3:0]       src_sel,
   output logic [2:0]       alu_func,
   output logic             alu_sx,
   output logic             alu_sy,
   output logic [7:0]       ir_q,
   output logic [7:0]       pc_q,
   output logic [CNT_W-1:0] instr_cnt,
   output logic [CNT_W-1:0] jmp_taken_cnt
);

   logic             dont_jmp_q, dont_jmp_d;
   logic [7:0]       ir_d, pc_d;
   logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
   logic [CNT_W-1:0] jmp_cnt_q, jmp_cnt_d;
   logic             alu_update;
   logic             jmp_taken;

   // Combinational decode of the current instruction; everything is held at zero during reset.
   always_comb begin
      reg_en   = '0;
      src_sel  = '0;
      alu_func = '0;
      alu_sx   = 1'b0;
      alu_sy   = 1'b0;
      jmp      = 1'b0;
      jmp_nz   = 1'b0;
      jmp_addr = '0;
      NOPC8    = 1'b0;
      NOPCF    = 1'b0;
      NOPD8    = 1'b0;
      NOPDF    = 1'b0;
      if (!sync_reset) begin
         jmp_addr = pm_data[3:0];
         NOPC8    = (pm_data == 8'hC8);
         NOPCF    = (pm_data == 8'hCF);
         NOPD8    = (pm_data == 8'hD8);
         NOPDF    = (pm_data == 8'hDF);
         if (!pm_data[7]) begin
            // load immediate: destination in [6:4], operand is the low nibble
            reg_en  = 8'b1 << pm_data[6:4];
            src_sel = 4'h8;
         end else if (!pm_data[6]) begin
            // move: a self-move writes nothing
            src_sel = {1'b0, pm_data[2:0]};
            if (pm_data[5:3] != pm_data[2:0]) begin
               reg_en = 8'b1 << pm_data[5:3];
            end
         end else if (!pm_data[5]) begin
            alu_sx   = pm_data[4];
            alu_sy   = pm_data[3];
            alu_func = pm_data[2:0];
         end else if (!pm_data[4]) begin
            jmp = 1'b1;
         end else begin
            jmp_nz = 1'b1;
         end
      end
   end

   // Next-state for the zero flag, pipeline copies and saturating counters.
   always_comb begin
      alu_update  = (pm_data[7:5] == 3'b110) && (pm_data[2:0] != 3'b000);
      // jmp_nz looks at the flag as it was before this edge
      jmp_taken   = jmp | (jmp_nz & ~dont_jmp_q);
      dont_jmp_d  = alu_update ? alu_zero : dont_jmp_q;
      ir_d        = pm_data;
      pc_d        = pc;
      instr_cnt_d = (&instr_cnt_q) ? instr_cnt_q : instr_cnt_q + CNT_W'(1);
      jmp_cnt_d   = (jmp_taken && !(&jmp_cnt_q)) ? jmp_cnt_q + CNT_W'(1) : jmp_cnt_q;
   end

   // State register; reset discards every update computed in the same cycle.
   always_ff @(posedge clk) begin
      if (sync_reset) begin
         dont_jmp_q  <= 1'b0;
         ir_q        <= '0;
         pc_q        <= '0;
         instr_cnt_q <= '0;
         jmp_cnt_q   <= '0;
      end else begin
         dont_jmp_q  <= dont_jmp_d;
         ir_q        <= ir_d;
         pc_q        <= pc_d;
         instr_cnt_q <= instr_cnt_d;
         jmp_cnt_q   <= jmp_cnt_d;
      end
   end

   assign dont_jmp      = dont_jmp_q;
   assign instr_cnt     = instr_cnt_q;
   assign jmp_taken_cnt = jmp_cnt_q;

endmodule

// File: doc/instruction_decoder.md
Name: instruction_decoder

Overview:
Decode stage of the 8-bit microprocessor. It sits between program memory and the datapath, directly feeding the program sequencer.
- Decodes the current instruction word (pm_data, already registered by program memory at pc) combinationally into datapath enables and sequencer controls: jmp, jmp_nz, jmp_addr, dont_jmp and the NOP strobes.
- Owns the zero flag, the ir_q/pc_q pipeline copies and the debug counters.

Parameters:
CNT_W, 8, width of instr_cnt and jmp_taken_cnt (saturating)

Ports:
clk  input  1  system clock, all state updates on rising edge
sync_reset  input  1  synchronous active-high reset
pm_data  input  8  current instruction word from program memory
pc  input  8  current program counter (address of pm_data)
alu_zero  input  1  ALU result==0 for the current ALU instruction
jmp  output  1  unconditional jump, to sequencer
jmp_nz  output  1  jump-if-not-zero instruction, to sequencer
jmp_addr  output  4  jump target high nibble, to sequencer
dont_jmp  output  1  registered zero flag, to sequencer
NOPC8  output  1  pm_data==8'hC8
NOPCF  output  1  pm_data==8'hCF
NOPD8  output  1  pm_data==8'hD8
NOPDF  output  1  pm_data==8'hDF
reg_en  output  8  one-hot destination write enable
src_sel  output  4  datapath source mux select
alu_func  output  3  ALU function
alu_sx  output  1  ALU x-operand select
alu_sy  output  1  ALU y-operand select
ir_q  output  8  pm_data delayed one cycle
pc_q  output  8  pc delayed one cycle
instr_cnt  output  CNT_W  instructions executed since reset, saturating
jmp_taken_cnt  output  CNT_W  taken jumps since reset, saturating

Behaviour:
Instruction formats (decode is combinational from pm_data, zero-cycle latency):
- pm_data[7]=0, load immediate:
  - reg_en one-hot at index pm_data[6:4].
  - src_sel=4'h8 (immediate pm_data[3:0]).
- pm_data[7:6]=10, move:
  - reg_en one-hot at index pm_data[5:3].
  - src_sel={1'b0,pm_data[2:0]}.
  - Special case: dst==src: reg_en=0, no write.
- pm_data[7:5]=110, ALU:
  - alu_sx=pm_data[4], alu_sy=pm_data[3], alu_func=pm_data[2:0].
  - reg_en=0.
  - func 3'b000 is a no-op.
- pm_data[7:4]=1110: jmp=1.
- pm_data[7:4]=1111: jmp_nz=1.
- jmp_addr=pm_data[3:0] always; it is only meaningful with jmp or jmp_nz.
- Defaults for fields not driven by the instruction: reg_en=0, src_sel=0, alu_*=0, jmp=jmp_nz=0.
- NOP strobes are exact 8-bit compares, independent of class decode.

Reset:
- While sync_reset=1, all combinational outputs are forced to 0: reg_en, jmp, jmp_nz, NOP strobes. jmp_addr, src_sel and alu_* are also 0.
- Registered outputs take their reset values on a clock edge with sync_reset=1: dont_jmp=0, ir_q=0, pc_q=0, instr_cnt=0, jmp_taken_cnt=0.
- Reset asserted mid-operation clears all of the above on the next edge, with no partial update. Flag and counter updates in that cycle are discarded.

Zero flag:
- dont_jmp <= alu_zero on an edge where the current instruction is ALU with func!=000.
- Otherwise dont_jmp holds (loads, moves, jumps and ALU no-op leave it unchanged).
- The flag written by an ALU instruction is visible to a jmp_nz in the next cycle.

Pipeline copies:
- ir_q <= pm_data and pc_q <= pc every non-reset edge.

Counters:
- instr_cnt increments every non-reset edge and saturates at 2^CNT_W-1.
- jmp_taken_cnt increments when (jmp) or (jmp_nz && !dont_jmp), using the pre-edge flag. It saturates at 2^CNT_W-1.
- Saturation holds the all-ones value with no wrap.

Simultaneous events:
- An ALU instruction cannot also be a jump, so no ordering conflict exists.
- jmp_nz uses the dont_jmp value from before this edge, never the flag being written.

Test Plan:
- Reset then pm_data=8'h35 -> reg_en=8'b0000_1000, src_sel=8; next edge ir_q=8'h35, instr_cnt=1.
- ALU 8'hC9 with alu_zero=1 -> next cycle dont_jmp=1; then pm_data=8'hF4 -> jmp_nz=1, jmp_addr=4; jmp_taken_cnt unchanged.
- ALU 8'hC9 with alu_zero=0, then 8'hF4 -> dont_jmp=0; jmp_taken_cnt increments by 1. Then 8'hC8 -> NOPC8=1 and dont_jmp holds 0.
- pm_data=8'hE7 -> jmp=1, jmp_addr=7, jmp_taken_cnt+1. Move 8'h92 (dst=src=2) -> reg_en=0.
- CNT_W=4, run 20 cycles -> instr_cnt sticks at 15.
- sync_reset asserted mid-stream with dont_jmp=1, counters nonzero and pm_data=8'hE3 -> jmp=0 during reset; after the edge dont_jmp, ir_q, pc_q and both counters are 0.
